// File: rtl/hwag_pkg.sv
// hwag_pkg: shared types and constants for the HWAG tooth-capture logic.
package hwag_pkg;
    typedef enum logic {WAIT_FIRST, MEASURE} state_t;
    localparam int GAP_SHIFT = 1;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchronizer with a selectable rising/falling edge detector.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic srst,
    input  logic d,
    input  logic edge_sel,
    output logic edge_pulse
);
    logic [STAGES-1:0] sync;
    logic dly;
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else if (srst) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            dly  <= sync[STAGES-1];
        end
    end
    assign edge_pulse = edge_sel ? (dly & ~sync[STAGES-1]) : (~dly & sync[STAGES-1]);
endmodule

// File: rtl/tooth_period_capture.sv
// tooth_period_capture: measures clk cycles between active tooth edges,
// flags the reference gap and hands periods over with a valid/ack handshake.
module tooth_period_capture
    import hwag_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             ena,
    input  logic             cap_in,
    input  logic             edge_sel,
    input  logic             ack,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] period_prev,
    output logic             valid,
    output logic             lost,
    output logic             gap,
    output logic             stall
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             prev_ok;
    logic             edge_pulse;
    logic [WIDTH:0]   limit;
    logic             gap_next;
    edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
        .clk        (clk),
        .arst       (arst),
        .srst       (srst),
        .d          (cap_in),
        .edge_sel   (edge_sel),
        .edge_pulse (edge_pulse)
    );
    // One extra bit keeps 1.5x the old period from wrapping near full scale.
    assign limit    = {1'b0, period} + {1'b0, period >> GAP_SHIFT};
    assign gap_next = prev_ok & ({1'b0, cnt} > limit);
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= WAIT_FIRST;
            cnt         <= '0;
            prev_ok     <= 1'b0;
            period      <= '0;
            period_prev <= '0;
            valid       <= 1'b0;
            lost        <= 1'b0;
            gap         <= 1'b0;
            stall       <= 1'b0;
        end else if (srst) begin
            state       <= WAIT_FIRST;
            cnt         <= '0;
            prev_ok     <= 1'b0;
            period      <= '0;
            period_prev <= '0;
            valid       <= 1'b0;
            lost        <= 1'b0;
            gap         <= 1'b0;
            stall       <= 1'b0;
        end else begin
            if (ack && valid) begin
                valid <= 1'b0;
                lost  <= 1'b0;
            end
            if (ena) begin
                if (state == WAIT_FIRST) begin
                    if (edge_pulse) begin
                        cnt   <= WIDTH'(1);
                        state <= MEASURE;
                        stall <= 1'b0;
                    end
                end else if (edge_pulse) begin
                    period      <= cnt;
                    period_prev <= period;
                    cnt         <= WIDTH'(1);
                    valid       <= 1'b1;
                    lost        <= valid & ~ack;
                    gap         <= gap_next;
                    prev_ok     <= 1'b1;
                end else if (cnt == CNT_MAX) begin
                    stall   <= 1'b1;
                    state   <= WAIT_FIRST;
                    prev_ok <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tooth_period_capture.sv
// tb_tooth_period_capture: random tooth wheels on a 24-bit and an 8-bit instance,
// compared every cycle against a timestamp-based reference model.
module tb_tooth_period_capture;
    import hwag_pkg::*;
    logic clk = 1'b0;
    logic arst, srst, ena, cap_in, edge_sel, ack;
    logic [23:0] period24, pprev24;
    logic [7:0]  period8, pprev8;
    logic v24, l24, g24, s24, v8, l8, g8, s8;
    int n_checks = 0;
    int n_fail = 0;
    int ack_p = 0;
    bit rnd = 0;
    always #5 clk = ~clk;
    tooth_period_capture #(.WIDTH(24), .SYNC_STAGES(2)) dut24 (
        .clk(clk), .arst(arst), .srst(srst), .ena(ena), .cap_in(cap_in), .edge_sel(edge_sel),
        .ack(ack), .period(period24), .period_prev(pprev24), .valid(v24), .lost(l24),
        .gap(g24), .stall(s24)
    );
    tooth_period_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .arst(arst), .srst(srst), .ena(ena), .cap_in(cap_in), .edge_sel(edge_sel),
        .ack(ack), .period(period8), .period_prev(pprev8), .valid(v8), .lost(l8),
        .gap(g8), .stall(s8)
    );
    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: periods are differences of enabled-cycle timestamps between accepted edges.
    longint max_cnt[2] = '{64'd16777215, 64'd255};
    longint ena_time[2], t_last[2], m_period[2], m_prev[2];
    bit m_meas[2], m_valid[2], m_lost[2], m_gap[2], m_stall[2], m_ok[2];
    logic [2:0] hist = 3'b0;
    task automatic model_step(input int w, input bit rst, input bit e);
        bit nv, nl;
        if (rst) begin
            m_meas[w] = 0; m_valid[w] = 0; m_lost[w] = 0; m_gap[w] = 0; m_stall[w] = 0;
            m_ok[w] = 0; m_period[w] = 0; m_prev[w] = 0;
            return;
        end
        nv = m_valid[w];
        nl = m_lost[w];
        if (ack && m_valid[w]) begin nv = 0; nl = 0; end
        if (ena) begin
            if (!m_meas[w]) begin
                if (e) begin m_meas[w] = 1; t_last[w] = ena_time[w]; m_stall[w] = 0; end
            end else if (e) begin
                m_gap[w] = m_ok[w] && (2 * (ena_time[w] - t_last[w]) > 3 * m_period[w]);
                m_prev[w] = m_period[w];
                m_period[w] = ena_time[w] - t_last[w];
                t_last[w] = ena_time[w];
                if (m_valid[w] && !ack) nl = 1;
                nv = 1;
                m_ok[w] = 1;
            end else if (ena_time[w] - t_last[w] == max_cnt[w]) begin
                m_stall[w] = 1; m_meas[w] = 0; m_ok[w] = 0;
            end
            ena_time[w]++;
        end
        m_valid[w] = nv;
        m_lost[w] = nl;
    endtask
    // The DUT acts on the level sampled two edges ago against the one before it.
    always @(posedge clk) begin
        bit rst_now, e;
        rst_now = !arst || srst;
        e = edge_sel ? (hist[2] && !hist[1]) : (hist[1] && !hist[2]);
        for (int w = 0; w < 2; w++) model_step(w, rst_now, e);
        hist = rst_now ? 3'b0 : {hist[1:0], cap_in};
        #1;
        check("period24", period24, m_period[0]);
        check("prev24", pprev24, m_prev[0]);
        check("valid24", v24, m_valid[0]);
        check("lost24", l24, m_lost[0]);
        check("gap24", g24, m_gap[0]);
        check("stall24", s24, m_stall[0]);
        check("period8", period8, m_period[1]);
        check("prev8", pprev8, m_prev[1]);
        check("valid8", v8, m_valid[1]);
        check("lost8", l8, m_lost[1]);
        check("gap8", g8, m_gap[1]);
        check("stall8", s8, m_stall[1]);
    end
    task automatic tooth(input int p);
        for (int i = 0; i < p; i++) begin
            cap_in = (i < p / 2);
            ack = ($urandom_range(0, 99) < ack_p);
            if (rnd) begin
                ena = ($urandom_range(0, 9) != 0);
                srst = ($urandom_range(0, 499) == 0);
            end
            @(negedge clk);
        end
    endtask
    initial begin
        for (int w = 0; w < 2; w++) begin ena_time[w] = 0; t_last[w] = 0; end
        arst = 0; srst = 0; ena = 1; cap_in = 0; edge_sel = 0; ack = 0;
        repeat (10) begin @(negedge clk); cap_in = ~cap_in; end
        check("rst_period", period24, 0);
        check("rst_valid", v24, 0);
        @(negedge clk);
        arst = 1;
        repeat (3) @(negedge clk);
        tooth(100);
        check("rearm_valid", v24, 0);
        check("rearm_state", int'(dut24.state), int'(MEASURE));
        ack_p = 30;
        repeat (3) tooth(100);
        check("steady_period", period24, 100);
        check("steady_prev", pprev24, 100);
        check("steady_gap", g24, 0);
        tooth(149); tooth(100);
        check("p149_period", period24, 149);
        check("p149_gap", g24, 0);
        tooth(151); tooth(100);
        check("p151_period", period24, 151);
        check("p151_gap", g24, 1);
        tooth(100); tooth(100); tooth(300); tooth(100);
        check("missing_period", period24, 300);
        check("missing_gap", g24, 1);
        tooth(100);
        check("after_gap", g24, 0);
        check("after_prev", pprev24, 300);
        ack_p = 0;
        repeat (3) tooth(50);
        check("lost_flag", l24, 1);
        check("lost_period", period24, 50);
        ack_p = 50;
        repeat (30) tooth($urandom_range(2, 20));
        cap_in = 0;
        repeat (300) @(negedge clk);
        check("ovf_stall", s8, 1);
        tooth(50);
        check("ovf_clear", s8, 0);
        tooth(50);
        check("ovf_period", period8, 50);
        check("ovf_gap", g8, 0);
        tooth(60);
        cap_in = 1; repeat (10) @(negedge clk);
        ena = 0;
        for (int i = 0; i < 20; i++) begin cap_in = (i % 6) < 3; @(negedge clk); end
        ena = 1;
        repeat (3) tooth(70);
        edge_sel = 1;
        repeat (5) tooth($urandom_range(20, 80));
        cap_in = 1; repeat (17) @(negedge clk);
        srst = 1; @(negedge clk); srst = 0;
        check("srst_valid", v24, 0);
        edge_sel = 0;
        repeat (4) tooth(40);
        rnd = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) edge_sel = ~edge_sel;
            if ($urandom_range(0, 49) == 0) begin
                arst = 0; @(negedge clk); arst = 1;
            end
            tooth($urandom_range(2, 60));
        end
        rnd = 0; ena = 1; srst = 0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tooth_period_capture.md
# tooth_period_capture

Measures the clock-cycle period between successive active edges of the crank/cam tooth signal and hands each measured period to the angle-generation logic. It detects the reference gap from the ratio of consecutive periods. It is the input-side counterpart of the loadable up/down counter: the counter generates counts, this block samples and reports them. It sits between the raw tooth input pin and the HWAG phase/angle logic.

## Interface
- WIDTH, 24: period counter and output width in bits.
- SYNC_STAGES, 2: input synchronizer depth (≥2).

- clk  in  1  single system clock; all logic on rising edge.
- arst  in  1  asynchronous reset, active-low (asserted at 0), released synchronously by the integrator.
- srst  in  1  synchronous clear; same effect as arst, one cycle.
- ena  in  1  1 = measure; 0 = freeze counter and FSM, ignore edges (ack still honoured).
- cap_in  in  1  asynchronous tooth signal.
- edge_sel  in  1  0 = rising edge active, 1 = falling edge active.
- ack  in  1  consumer acknowledges current period.
- period  out  WIDTH  last captured period, in clk cycles.
- period_prev  out  WIDTH  period captured before `period`.
- valid  out  1  `period` holds unacknowledged data.
- lost  out  1  a capture overwrote unacknowledged data.
- gap  out  1  `period` > 1.5 × `period_prev`.
- stall  out  1  counter saturated with no edge; measurement restarted.

## Operation
- FSM states: WAIT_FIRST, MEASURE. Reset state is WAIT_FIRST.
- Active edge: the synchronized level changes in the direction selected by edge_sel, detected against a one-flop delayed copy.
- WAIT_FIRST, on an active edge with ena=1:
  - cnt←1, go to MEASURE, clear stall.
  - No capture.
- MEASURE, each ena cycle without an edge: cnt←cnt+1, saturating at 2^WIDTH−1.
- MEASURE, cnt at saturation with no edge: stall←1, go to WAIT_FIRST. No capture.
- MEASURE, on an active edge:
  - period←cnt and period_prev←period.
  - cnt←1, valid←1.
  - gap←(prev_ok && cnt > period + (period>>1)). The compare uses WIDTH+1 bits and the old `period` value.
  - prev_ok←1.
- `period` therefore equals the exact number of clk cycles between two active edges.
- prev_ok is internal. It is set by the first capture after reset or stall, so gap=0 on the first capture.
- Handshake:
  - ack with valid=1 clears valid and lost.
  - A capture while valid=1 and ack=0 overwrites `period` and sets lost.
  - Capture and ack in the same cycle: valid stays 1 with the new data, and lost is cleared, not set.
  - ack with valid=0 has no effect.
- Stall clears prev_ok. period, period_prev and valid are retained.
- edge_sel change: takes effect the next cycle. It may cause one spurious detection, which the integrator must avoid.

## Timing
- Reset values (arst or srst): period=0, period_prev=0, valid=0, lost=0, gap=0, stall=0, cnt=0, sync chain=0, FSM=WAIT_FIRST.
- Latency: with SYNC_STAGES=2, valid/period update on the 3rd rising clk edge that samples the new cap_in level. The latency is constant, so periods are exact.
- All outputs are registered. There is no combinational path from any input to any output.
- An arst assertion mid-measurement discards the count. The first edge after release re-arms only; it does not capture.
- Minimum period measurable: 2 cycles. Shorter pulses are undefined.

## Structure
- Package `hwag_pkg`:
  - FSM state typedef: WAIT_FIRST, MEASURE.
  - Gap-ratio shift constant GAP_SHIFT=1.
- Sub-module `edge_sync`: parametric synchronizer plus edge detector, with ports clk, arst, srst, d, edge_sel, edge_pulse. Reused for cam input later.
- cnt saturation and capture logic stay in the top module.

## Test plan
- Reset: hold arst=0, toggle cap_in → all outputs 0. Release; first rising edge → no valid, FSM in MEASURE.
- Steady wheel, WIDTH=24: rising edges every 100 cycles → period=100, valid pulses; after the second capture period_prev=100, gap=0. Edge every 149 after a 100 → gap=0. Edge every 151 after a 100 → gap=1.
- 60-2 pattern: periods 100,100,300,100 → gap=1 only on the 300 capture, then gap=0 with period_prev=300.
- Handshake: no ack across two captures → lost=1, period holds the newest value. ack in the same cycle as a capture → valid=1, lost=0.
- Overflow, WIDTH=8: no edge for 300 cycles → stall=1 after 255 counts. Next edge → no capture, stall=0. Following edge at +50 → period=50, gap=0.
- Control: ena=0 for 20 cycles mid-period → count frozen and edges ignored. edge_sel=1 → falling edges measured, rising edges ignored. srst mid-period → same state as arst.
